// File: rtl/renode_axi_sram_subordinate_if.sv
// AXI4 bus bundle between the Renode AXI manager and the SRAM subordinate.
// Lock and prot are intentionally absent; the subordinate ignores them.
interface renode_axi_sram_subordinate_if #(
   parameter int AddressWidth       = 20,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8
);
   localparam int StrobeWidth = DataWidth / 8;

   logic [TransactionIdWidth-1:0] awid;
   logic [AddressWidth-1:0]       awaddr;
   logic [7:0]                    awlen;
   logic [2:0]                    awsize;
   logic [1:0]                    awburst;
   logic                          awvalid;
   logic                          awready;

   logic [DataWidth-1:0]          wdata;
   logic [StrobeWidth-1:0]        wstrb;
   logic                          wlast;
   logic                          wvalid;
   logic                          wready;

   logic [TransactionIdWidth-1:0] bid;
   logic [1:0]                    bresp;
   logic                          bvalid;
   logic                          bready;

   logic [TransactionIdWidth-1:0] arid;
   logic [AddressWidth-1:0]       araddr;
   logic [7:0]                    arlen;
   logic [2:0]                    arsize;
   logic [1:0]                    arburst;
   logic                          arvalid;
   logic                          arready;

   logic [TransactionIdWidth-1:0] rid;
   logic [DataWidth-1:0]          rdata;
   logic [1:0]                    rresp;
   logic                          rlast;
   logic                          rvalid;
   logic                          rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/renode_axi_sram_subordinate.sv
// AXI4 SRAM target for the Renode co-simulation: independent write (AW/W/B) and
// read (AR/R) FSMs over a byte-strobed, word-addressed RAM.
module renode_axi_sram_subordinate #(
   parameter int AddressWidth       = 20,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8,
   parameter int MemDepthWords      = 1024
) (
   input logic                          aclk,
   input logic                          areset,
   renode_axi_sram_subordinate_if.slave axi
);
   localparam int StrobeWidth = DataWidth / 8;
   localparam int OffW        = $clog2(StrobeWidth);
   localparam int IdxW        = $clog2(MemDepthWords);
   localparam logic [1:0] RespOkay   = 2'd0;
   localparam logic [1:0] RespSlverr = 2'd2;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

   function automatic logic in_range(input logic [AddressWidth-1:0] a);
      return (a >> OffW) < AddressWidth'(MemDepthWords);
   endfunction

   function automatic logic [IdxW-1:0] word_idx(input logic [AddressWidth-1:0] a);
      return IdxW'(a >> OffW);
   endfunction

   function automatic logic is_bad(input logic [1:0] burst, input logic [2:0] size,
                                   input logic [7:0] len);
      return (burst > 2'd1) || (size > 3'(OffW)) || (len > 8'd15);
   endfunction

   // FIXED holds the address; INCR aligns down to the transfer size, then steps.
   function automatic logic [AddressWidth-1:0] next_addr(input logic [AddressWidth-1:0] a,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
      logic [AddressWidth-1:0] step;
      step = AddressWidth'(1) << size;
      return (burst == 2'd0) ? a : ((a & ~(step - 1'b1)) + step);
   endfunction

   logic [DataWidth-1:0] mem [MemDepthWords];

   w_state_e                      w_state_q, w_state_d;
   logic [TransactionIdWidth-1:0] aw_id_q, aw_id_d, bid_q, bid_d;
   logic [AddressWidth-1:0]       w_addr_q, w_addr_d;
   logic [2:0]                    w_size_q, w_size_d;
   logic [1:0]                    w_burst_q, w_burst_d, bresp_q, bresp_d;
   logic [7:0]                    w_len_q, w_len_d;
   logic [8:0]                    w_cnt_q, w_cnt_d;
   logic                          w_bad_q, w_bad_d, w_err_q, w_err_d;
   logic                          awready_q, wready_q, bvalid_q, w_hs, mem_we;

   r_state_e                      r_state_q, r_state_d;
   logic [TransactionIdWidth-1:0] ar_id_q, ar_id_d, rid_q, rid_d;
   logic [AddressWidth-1:0]       r_addr_q, r_addr_d;
   logic [2:0]                    r_size_q, r_size_d;
   logic [1:0]                    r_burst_q, r_burst_d, rresp_q, rresp_d;
   logic [7:0]                    r_rem_q, r_rem_d;
   logic                          r_bad_q, r_bad_d, rlast_q, rlast_d, r_ok;
   logic                          arready_q, rvalid_q;
   logic [DataWidth-1:0]          rdata_q;

   assign w_hs   = wready_q && axi.wvalid;
   assign mem_we = (w_state_q == W_DATA) && w_hs && !w_bad_q && in_range(w_addr_q);
   assign r_ok   = !r_bad_q && in_range(r_addr_q);

   // NOTE: every _d gets its hold value first so no path through the case leaves
   // it unassigned; a missing default here would infer a latch.
   always_comb begin
      w_state_d = w_state_q;
      aw_id_d   = aw_id_q;
      w_addr_d  = w_addr_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_len_d   = w_len_q;
      w_bad_d   = w_bad_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: if (axi.awvalid && awready_q) begin
            aw_id_d   = axi.awid;
            w_addr_d  = axi.awaddr;
            w_size_d  = axi.awsize;
            w_burst_d = axi.awburst;
            w_len_d   = axi.awlen;
            w_bad_d   = is_bad(axi.awburst, axi.awsize, axi.awlen);
            w_cnt_d   = '0;
            w_err_d   = 1'b0;
            w_state_d = W_DATA;
         end
         W_DATA: if (w_hs) begin
            if (w_bad_q || !in_range(w_addr_q)) w_err_d = 1'b1;
            w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
            w_cnt_d  = (w_cnt_q == '1) ? w_cnt_q : w_cnt_q + 9'd1;
            if (axi.wlast) begin
               if (w_cnt_d != {1'b0, w_len_q} + 9'd1) w_err_d = 1'b1;
               bid_d     = aw_id_q;
               bresp_d   = w_err_d ? RespSlverr : RespOkay;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (axi.bready && bvalid_q) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      ar_id_d   = ar_id_q;
      r_addr_d  = r_addr_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_rem_d   = r_rem_q;
      r_bad_d   = r_bad_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      case (r_state_q)
         R_IDLE: if (axi.arvalid && arready_q) begin
            ar_id_d   = axi.arid;
            r_addr_d  = axi.araddr;
            r_size_d  = axi.arsize;
            r_burst_d = axi.arburst;
            r_rem_d   = axi.arlen;
            r_bad_d   = is_bad(axi.arburst, axi.arsize, axi.arlen);
            r_state_d = R_FETCH;
         end
         R_FETCH: begin
            rid_d     = ar_id_q;
            rresp_d   = r_ok ? RespOkay : RespSlverr;
            rlast_d   = (r_rem_q == 8'd0);
            r_state_d = R_DATA;
         end
         R_DATA: if (axi.rready && rvalid_q) begin
            if (rlast_q) begin
               r_state_d = R_IDLE;
            end else begin
               r_rem_d   = r_rem_q - 8'd1;
               r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q);
               r_state_d = R_FETCH;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         aw_id_q   <= '0;
         w_addr_q  <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_len_q   <= '0;
         w_bad_q   <= 1'b0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         r_state_q <= R_IDLE;
         ar_id_q   <= '0;
         r_addr_q  <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_rem_q   <= '0;
         r_bad_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_id_q   <= aw_id_d;
         w_addr_q  <= w_addr_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_len_q   <= w_len_d;
         w_bad_q   <= w_bad_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         awready_q <= (w_state_d == W_IDLE);
         wready_q  <= (w_state_d == W_DATA);
         bvalid_q  <= (w_state_d == W_RESP);
         r_state_q <= r_state_d;
         ar_id_q   <= ar_id_d;
         r_addr_q  <= r_addr_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_rem_q   <= r_rem_d;
         r_bad_q   <= r_bad_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         arready_q <= (r_state_d == R_IDLE);
         rvalid_q  <= (r_state_d == R_DATA);
      end
   end

   // Registered read: a fetch on the same edge as a write sees the old word.
   always_ff @(posedge aclk) begin
      if (areset) rdata_q <= '0;
      else if (r_state_q == R_FETCH) rdata_q <= r_ok ? mem[word_idx(r_addr_q)] : '0;
   end

   // NOTE: the RAM has no reset so contents survive areset and map onto plain SRAM.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < StrobeWidth; b++) begin
            if (axi.wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
         end
      end
   end

   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bid     = bid_q;
   assign axi.bresp   = bresp_q;
   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rid     = rid_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.rlast   = rlast_q;
endmodule

// File: doc/renode_axi_sram_subordinate.md
# renode_axi_sram_subordinate

AXI4 subordinate memory that sits directly downstream of the Renode AXI manager. It accepts the manager's AR/AW/W transactions, stores data in an internal word-addressed RAM with byte strobes, and returns R/B responses. The co-simulation bench uses it as the memory target for Renode-driven reads and writes. The read and write paths are independent and run concurrently.

## Interface
- AddressWidth, 20, byte address width.
- DataWidth, 32, data bus width in bits; legal values 32 or 64. StrobeWidth = DataWidth/8.
- TransactionIdWidth, 8, AXI ID width.
- MemDepthWords, 1024, RAM depth in DataWidth words.
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset; one clock; reset is synchronous and active-high.
- awid/awaddr/awlen/awsize/awburst  in  TransactionIdWidth/AddressWidth/8/3/2  write address.
- awvalid in 1, awready out 1  AW handshake.
- wdata/wstrb/wlast  in  DataWidth/StrobeWidth/1  write data.
- wvalid in 1, wready out 1  W handshake.
- bid/bresp  out  TransactionIdWidth/2  write response; bvalid out 1, bready in 1.
- arid/araddr/arlen/arsize/arburst  in  TransactionIdWidth/AddressWidth/8/3/2  read address.
- arvalid in 1, arready out 1  AR handshake.
- rid/rdata/rresp/rlast  out  TransactionIdWidth/DataWidth/2/1  read data; rvalid out 1, rready in 1.
- The lock and prot signals are not ported.

## Operation
- Word index = addr >> log2(StrobeWidth). The address is in range when word index < MemDepthWords.
- Burst types:
  - FIXED (0): the address is held for every beat.
  - INCR (1): next addr = (addr & ~((1<<size)-1)) + (1<<size).
  - WRAP (2) and reserved (3) are unsupported.
- A burst is bad when any of these holds: the burst type is unsupported; size > log2(StrobeWidth); awlen/arlen > 15.
- Write FSM:
  - W_IDLE (awready=1): on the AW handshake, latch id, addr, size, burst, len and the bad flag; clear the beat counter and sticky error; go to W_DATA.
  - W_DATA (wready=1): on each W handshake, if the burst is good and the address is in range, write every byte lane where wstrb=1. Bad burst or out-of-range address: do not write, set the sticky error.
  - After each W handshake, advance the address and increment the beat counter.
  - On the handshake with wlast=1, go to W_RESP. If the beat count differs from len+1, set the sticky error.
  - W_RESP (bvalid=1): bid = latched id; bresp = SLVERR (2) if the sticky error is set, else OKAY (0). On bready, go to W_IDLE.
- Read FSM:
  - R_IDLE (arready=1): on the AR handshake, latch the fields and remaining = arlen; go to R_FETCH.
  - R_FETCH (one cycle): register the RAM read. Out-of-range address or bad burst gives rdata=0 and rresp=SLVERR, else OKAY. Go to R_DATA.
  - R_DATA (rvalid=1): rlast = (remaining==0). On rready: if rlast, go to R_IDLE; else decrement remaining, advance the address and go to R_FETCH.
- Narrow transfers: rdata always carries the full word; the manager selects the lanes. On writes, wstrb is applied as given.
- Same-word collision: an R_FETCH on the same edge as a W_DATA write returns the pre-write data.

## Timing
- All outputs are registered. While areset=1, and on the first cycle after release:
  - awready=arready=wready=bvalid=rvalid=rlast=0;
  - bresp=rresp=0; bid=rid=0; rdata=0.
- awready and arready rise after the first edge sampled with areset=0.
- Write path:
  - AW handshake at edge T: wready=1 after T, awready=0 after T.
  - Last W handshake at edge U: bvalid=1 after U.
  - B handshake at edge V: awready=1 after V.
  - Minimum single-beat write is AW→B in 2 cycles.
- Read path:
  - AR handshake at edge T: rvalid=1 after T+1.
  - Each R handshake at edge U: next beat rvalid=1 after U+1, or arready=1 after U if that beat had rlast.
  - Throughput is one beat per 2 cycles; there is no prefetch.
- bvalid, rvalid and the response fields stay stable until their handshake.
- An early wlast ends the burst with SLVERR. A missing wlast keeps W_DATA open, writes beyond len+1 land at advancing addresses, and the response is SLVERR.
- Reset mid-transaction aborts both FSMs to IDLE. No response is issued. RAM contents are retained.

## Test plan
- Write id=0, addr=0x10, size=2, wdata=0xDEADBEEF, wstrb=0xF, then read 0x10 → bresp=OKAY, bid=0; rdata=0xDEADBEEF, rresp=OKAY, rlast=1, rvalid 2 cycles after the AR handshake.
- Narrow write addr=0x11, size=0, wstrb=0x2, wdata=0x0000AB00 over 0xDEADBEEF → readback 0xDEADABEF.
- INCR read arlen=3 from 0x20 after writing 1,2,3,4 → beats 1,2,3,4 with rlast only on beat 4. Repeat with rready held low 3 cycles on beat 2 → rdata/rvalid held, same data.
- Out of range: write addr=MemDepthWords*4 → bresp=SLVERR, no RAM change. Read of the same address → rdata=0, rresp=SLVERR. WRAP read → SLVERR.
- Concurrent write 0x55 and read to word 0x40 (old value 0x11) in the same cycle → read returns 0x11, later read returns 0x55; both responses OKAY.
- Assert areset during W_DATA of a 4-beat burst → bvalid never rises, awready=1 two edges after release, RAM beats already written persist.
